// File: rtl/fixed_point_divider.sv
// fixed_point_divider: sequential signed radix-2 restoring divider with saturation.
// Define FIXED_POINT_DIVIDER_ROUND_EN to round half away from zero (one extra cycle).
module fixed_point_divider #(
    parameter int WIDTH       = 32,
    parameter int FIXED_POINT = 0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] quotient_out,
    output logic             div_by_zero_out,
    output logic             overflow_out
);
    localparam int SH = FIXED_POINT != 0 ? WIDTH / 2 : 0;
    localparam int N  = WIDTH + SH;
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int NI = N + RB;
    localparam int CW = $clog2(NI + 1);

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NI-1:0]    num_q, num_d;
    logic [WIDTH-1:0] rem_q, rem_d, dvs_q, dvs_d, quo_q, quo_d;
    logic             neg_q, neg_d, dneg_q, dneg_d, dz_q, dz_d;
    logic             valid_q, valid_d, dzo_q, dzo_d, ovf_q, ovf_d;

    logic [WIDTH:0]   dvd_ext, dvd_mag, rem_sh;
    logic [WIDTH-1:0] dvs_mag, res, sat, sat_dz;
    logic [N:0]       mag, lim;
    logic             ge, ovf;

    // Numerator shifts out MSB-first while quotient bits fill in from the LSB end.
    always_comb begin
        dvd_ext = {dividend_in[WIDTH-1], dividend_in};
        dvd_mag = dividend_in[WIDTH-1] ? -dvd_ext : dvd_ext;
        dvs_mag = divisor_in[WIDTH-1] ? -divisor_in : divisor_in;
        rem_sh  = {rem_q, num_q[NI-1]};
        ge      = rem_sh >= {1'b0, dvs_q};
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
        mag     = {1'b0, num_q[NI-1:1]} + (N+1)'(num_q[0]);
`else
        mag     = {1'b0, num_q};
`endif
        lim     = {{(N+1-WIDTH){1'b0}}, neg_q, {(WIDTH-1){~neg_q}}};
        ovf     = mag > lim;
        res     = neg_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];
        sat     = {neg_q, {(WIDTH-1){~neg_q}}};
        sat_dz  = {dneg_q, {(WIDTH-1){~dneg_q}}};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        neg_d   = neg_q;
        dneg_d  = dneg_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        dzo_d   = dzo_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (valid_in) begin
                num_d   = NI'(dvd_mag) << (SH + RB);
                rem_d   = '0;
                dvs_d   = dvs_mag;
                neg_d   = dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1];
                dneg_d  = dividend_in[WIDTH-1];
                dz_d    = divisor_in == '0;
                cnt_d   = CW'(NI - 1);
                state_d = DIVIDE;
            end
            DIVIDE: begin
                rem_d   = ge ? rem_sh[WIDTH-1:0] - dvs_q : rem_sh[WIDTH-1:0];
                num_d   = {num_q[NI-2:0], ge};
                cnt_d   = cnt_q - CW'(1);
                state_d = cnt_q == '0 ? FINISH : DIVIDE;
            end
            FINISH: begin
                quo_d   = dz_q ? sat_dz : ovf ? sat : res;
                dzo_d   = dz_q;
                ovf_d   = !dz_q && ovf;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            dneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            dzo_q   <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            dneg_q  <= dneg_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            dzo_q   <= dzo_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign ready_out       = state_q == IDLE;
    assign valid_out       = valid_q;
    assign quotient_out    = quo_q;
    assign div_by_zero_out = dzo_q;
    assign overflow_out    = ovf_q;
endmodule

// File: tb/tb_fixed_point_divider.sv
// tb_fixed_point_divider: checks a Q16.16 32-bit instance and a 16-bit integer instance
// against an arithmetic reference model, including handshake, latency and reset abort.
module tb_fixed_point_divider;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v32, r32, vo32, dz32, ov32;
    logic [31:0] a32, b32, q32;
    logic        v16, r16, vo16, dz16, ov16;
    logic [15:0] a16, b16, q16;
    int vectors = 0;
    int errors  = 0;

`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int LAT32 = 49 + RB;
    localparam int LAT16 = 17 + RB;

    fixed_point_divider #(.WIDTH(32), .FIXED_POINT(1)) u_fp (
        .clk_in(clk), .rst_in(rst), .valid_in(v32), .ready_out(r32),
        .dividend_in(a32), .divisor_in(b32), .valid_out(vo32),
        .quotient_out(q32), .div_by_zero_out(dz32), .overflow_out(ov32)
    );

    fixed_point_divider #(.WIDTH(16), .FIXED_POINT(0)) u_int (
        .clk_in(clk), .rst_in(rst), .valid_in(v16), .ready_out(r16),
        .dividend_in(a16), .divisor_in(b16), .valid_out(vo16),
        .quotient_out(q16), .div_by_zero_out(dz16), .overflow_out(ov16)
    );

    // Reference: exact integer division on sign-extended values, then saturate.
    function automatic logic [31:0] model(input int w, input bit fp, input logic [31:0] ar,
                                          input logic [31:0] br, output logic dz, output logic ov);
        longint a, b, num, an, ab, m, rm, r, mx, mn, msk;
        msk = (longint'(1) << w) - 1;
        a = longint'(ar) & msk;
        b = longint'(br) & msk;
        if (a > (msk >> 1)) a -= longint'(1) << w;
        if (b > (msk >> 1)) b -= longint'(1) << w;
        mx = msk >> 1;
        mn = -mx - 1;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            dz = 1'b1;
            r = a >= 0 ? mx : mn;
        end else begin
            num = fp ? a * (longint'(1) << (w / 2)) : a;
            an = num < 0 ? -num : num;
            ab = b < 0 ? -b : b;
            m = an / ab;
            rm = an % ab;
            if (RB == 1 && 2 * rm >= ab) m++;
            r = ((num < 0) != (b < 0)) ? -m : m;
            if (r > mx) begin r = mx; ov = 1'b1; end
            if (r < mn) begin r = mn; ov = 1'b1; end
        end
        return 32'(r & msk);
    endfunction

    task automatic start32(input logic [31:0] a, input logic [31:0] b);
        v32 = 1'b1; a32 = a; b32 = b;
        @(posedge clk); #1;
        v32 = 1'b0; a32 = $urandom; b32 = $urandom;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b);
        v16 = 1'b1; a16 = a; b16 = b;
        @(posedge clk); #1;
        v16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    endtask

    task automatic wait32(output logic [31:0] q, output logic dz, output logic ov,
                          output int lat, output bit rok);
        lat = 0; rok = 1'b1;
        for (int k = 1; k <= LAT32 + 4; k++) begin
            @(posedge clk); #1;
            if (vo32) begin lat = k; break; end
            if (r32) rok = 1'b0;
        end
        q = q32; dz = dz32; ov = ov32;
    endtask

    task automatic wait16(output logic [15:0] q, output logic dz, output logic ov,
                          output int lat, output bit rok);
        lat = 0; rok = 1'b1;
        for (int k = 1; k <= LAT16 + 4; k++) begin
            @(posedge clk); #1;
            if (vo16) begin lat = k; break; end
            if (r16) rok = 1'b0;
        end
        q = q16; dz = dz16; ov = ov16;
    endtask

    task automatic test_reset();
        rst = 1'b1; v32 = 1'b0; v16 = 1'b0;
        a32 = '0; b32 = '0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        vectors++;
        if ({r32, vo32, q32, dz32, ov32} !== {1'b1, 1'b0, 32'h0, 2'b00})
            $display("FAIL reset32: got rdy=%b v=%b q=%h dz=%b ov=%b, need 1 0 00000000 0 0", r32, vo32, q32, dz32, ov32);
        vectors++;
        if ({r16, vo16, q16, dz16, ov16} !== {1'b1, 1'b0, 16'h0, 2'b00})
            $display("FAIL reset16: got rdy=%b v=%b q=%h dz=%b ov=%b, need 1 0 0000 0 0", r16, vo16, q16, dz16, ov16);
        if ({r32, vo32, q32, dz32, ov32} !== {1'b1, 1'b0, 32'h0, 2'b00}) errors++;
        if ({r16, vo16, q16, dz16, ov16} !== {1'b1, 1'b0, 16'h0, 2'b00}) errors++;
    endtask

    task automatic test_fp_basic();
        logic [31:0] q; logic dz, ov; int lat; bit rok;
        start32(32'h0003_0000, 32'h0002_0000);
        vectors++;
        if (r32 !== 1'b0) begin errors++; $display("FAIL fp_ready_fall: got %b need 0", r32); end
        wait32(q, dz, ov, lat, rok);
        vectors++;
        if (lat !== LAT32) begin errors++; $display("FAIL fp_latency: got %0d need %0d", lat, LAT32); end
        vectors++;
        if (q !== 32'h0001_8000) begin errors++; $display("FAIL fp_3div2: got %h need 00018000", q); end
        vectors++;
        if ({dz, ov} !== 2'b00) begin errors++; $display("FAIL fp_3div2_flags: got %b need 00", {dz, ov}); end
        vectors++;
        if (!rok) begin errors++; $display("FAIL fp_ready_busy: got ready high during divide need low"); end
        vectors++;
        if (r32 !== 1'b1) begin errors++; $display("FAIL fp_ready_at_valid: got %b need 1", r32); end
        @(posedge clk); #1;
        vectors++;
        if (vo32 !== 1'b0) begin errors++; $display("FAIL fp_valid_pulse: got %b need 0", vo32); end
    endtask

    task automatic test_fp_special();
        logic [31:0] ta [5] = '{32'hFFF9_0000, 32'h0005_0000, 32'hFFFB_0000, 32'h7FFF_0000, 32'h0000_0000};
        logic [31:0] tb [5] = '{32'h0002_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0100, 32'h0000_0000};
        logic [31:0] tq [5] = '{32'hFFFC_8000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        logic [1:0]  tf [5] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10};
        logic [31:0] q; logic dz, ov; int lat; bit rok;
        for (int i = 0; i < 5; i++) begin
            start32(ta[i], tb[i]);
            wait32(q, dz, ov, lat, rok);
            vectors++;
            if (q !== tq[i]) begin errors++; $display("FAIL fp_special[%0d] q: got %h need %h", i, q, tq[i]); end
            vectors++;
            if ({dz, ov} !== tf[i]) begin errors++; $display("FAIL fp_special[%0d] dz/ov: got %b need %b", i, {dz, ov}, tf[i]); end
            vectors++;
            if (lat !== LAT32) begin errors++; $display("FAIL fp_special[%0d] latency: got %0d need %0d", i, lat, LAT32); end
        end
    endtask

    task automatic test_round();
        logic [31:0] q; logic dz, ov; int lat; bit rok;
        logic [31:0] exp_q;
        exp_q = RB == 1 ? 32'h0000_AAAB : 32'h0000_AAAA;
        start32(32'h0002_0000, 32'h0003_0000);
        wait32(q, dz, ov, lat, rok);
        vectors++;
        if (q !== exp_q) begin errors++; $display("FAIL round_2div3: got %h need %h", q, exp_q); end
        vectors++;
        if (lat !== LAT32) begin errors++; $display("FAIL round_latency: got %0d need %0d", lat, LAT32); end
    endtask

    task automatic test_int_special();
        logic [15:0] ta [4] = '{16'd100, 16'hFF9C, 16'h8000, 16'h8000};
        logic [15:0] tb [4] = '{16'd7,   16'd7,    16'hFFFF, 16'h0001};
        logic [15:0] tq [4] = '{16'd14,  16'hFFF2, 16'h7FFF, 16'h8000};
        logic [1:0]  tf [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
        logic [15:0] q; logic dz, ov; int lat; bit rok;
        for (int i = 0; i < 4; i++) begin
            start16(ta[i], tb[i]);
            wait16(q, dz, ov, lat, rok);
            vectors++;
            if (q !== tq[i]) begin errors++; $display("FAIL int_special[%0d] q: got %h need %h", i, q, tq[i]); end
            vectors++;
            if ({dz, ov} !== tf[i]) begin errors++; $display("FAIL int_special[%0d] dz/ov: got %b need %b", i, {dz, ov}, tf[i]); end
            vectors++;
            if (lat !== LAT16 || !rok) begin errors++; $display("FAIL int_special[%0d] timing: got lat %0d rok %b need %0d 1", i, lat, rok, LAT16); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q; logic dz, ov; int lat, pulses; bit rok;
        v16 = 1'b1; a16 = 16'd100; b16 = 16'd7;
        @(posedge clk); #1;
        a16 = 16'hFF9C;
        wait16(q, dz, ov, lat, rok);
        vectors++;
        if (q !== 16'd14 || lat !== LAT16) begin errors++; $display("FAIL b2b_first: got q %h lat %0d need 000e %0d", q, lat, LAT16); end
        vectors++;
        if (r16 !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b need 1", r16); end
        @(posedge clk); #1;
        v16 = 1'b0;
        wait16(q, dz, ov, lat, rok);
        vectors++;
        if (q !== 16'hFFF2 || lat !== LAT16) begin errors++; $display("FAIL b2b_second: got q %h lat %0d need fff2 %0d", q, lat, LAT16); end
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (vo16) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin errors++; $display("FAIL b2b_extra_results: got %0d pulses need 0", pulses); end
        vectors++;
        if (q16 !== 16'hFFF2) begin errors++; $display("FAIL b2b_hold: got %h need fff2", q16); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q; logic dz, ov; int lat, pulses; bit rok;
        start32(32'h0003_0000, 32'h0002_0000);
        repeat (20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({r32, vo32, q32, dz32, ov32} !== {1'b1, 1'b0, 32'h0, 2'b00})
            begin errors++; $display("FAIL mid_reset: got rdy=%b v=%b q=%h dz=%b ov=%b need 1 0 0 0 0", r32, vo32, q32, dz32, ov32); end
        pulses = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (vo32) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin errors++; $display("FAIL mid_reset_no_valid: got %0d pulses need 0", pulses); end
        start32(32'h0006_0000, 32'h0003_0000);
        wait32(q, dz, ov, lat, rok);
        vectors++;
        if (q !== 32'h0002_0000 || lat !== LAT32) begin errors++; $display("FAIL mid_reset_after: got q %h lat %0d need 00020000 %0d", q, lat, LAT32); end
    endtask

    task automatic test_random32();
        logic [31:0] a, b, q, eq; logic dz, ov, edz, eov; int lat; bit rok;
        for (int i = 0; i < 15; i++) begin
            a = $urandom >> $urandom_range(0, 16);
            b = $urandom >> $urandom_range(4, 30);
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            eq = model(32, 1'b1, a, b, edz, eov);
            start32(a, b);
            wait32(q, dz, ov, lat, rok);
            vectors++;
            if ({q, dz, ov} !== {eq, edz, eov} || lat !== LAT32)
                begin errors++; $display("FAIL rand32 %h/%h: got %h dz%b ov%b lat%0d need %h dz%b ov%b lat%0d", a, b, q, dz, ov, lat, eq, edz, eov, LAT32); end
        end
    endtask

    task automatic test_random16();
        logic [15:0] a, b, q; logic [31:0] eq; logic dz, ov, edz, eov; int lat; bit rok;
        for (int i = 0; i < 25; i++) begin
            a = 16'($urandom);
            b = 16'($urandom) >> $urandom_range(0, 14);
            if ($urandom_range(0, 1) == 1) b = -b;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 16'h8000;
                2: b = 16'hFFFF;
                default: ;
            endcase
            eq = model(16, 1'b0, {16'h0, a}, {16'h0, b}, edz, eov);
            start16(a, b);
            wait16(q, dz, ov, lat, rok);
            vectors++;
            if ({q, dz, ov} !== {eq[15:0], edz, eov} || lat !== LAT16)
                begin errors++; $display("FAIL rand16 %h/%h: got %h dz%b ov%b lat%0d need %h dz%b ov%b lat%0d", a, b, q, dz, ov, lat, eq[15:0], edz, eov, LAT16); end
        end
    endtask

    initial begin
        test_reset();
        test_fp_basic();
        test_fp_special();
        test_round();
        test_int_special();
        test_back_to_back();
        test_reset_mid();
        test_random32();
        test_random16();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Sequential signed divider: the inverse of the team's pipelined dot-product and multiply path.
- Used for the perspective divide and normalisation in the 3D pipeline.
- Radix-2 restoring divide on magnitudes, one quotient bit per cycle, single-slot valid/ready handshake.
- Shares the Q(WIDTH/2).(WIDTH/2) fixed-point convention with the dot-product unit.

Parameters:
- WIDTH, 32, operand and quotient width in bits (even, ≥8).
- FIXED_POINT, 0, 1: quotient = (dividend << WIDTH/2) / divisor, Q-format result; 0: plain integer quotient.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  synchronous, active-high reset.
- valid_in  input  1  operands valid; accepted when valid_in && ready_out.
- ready_out  output  1  high when IDLE (able to accept).
- dividend_in  input  WIDTH  signed dividend.
- divisor_in  input  WIDTH  signed divisor.
- valid_out  output  1  one-cycle pulse, result valid.
- quotient_out  output  WIDTH  signed quotient; holds until next result.
- div_by_zero_out  output  1  result flag, held with quotient_out.
- overflow_out  output  1  result flag (saturated), held with quotient_out.

Behaviour:
- Reset: state IDLE, ready_out=1, valid_out=0, quotient_out=0, both flags 0, counter=0, internal regs 0.
- N = WIDTH + (FIXED_POINT ? WIDTH/2 : 0) iterations. Internal numerator width N; remainder width WIDTH+1.
- IDLE: on accept, latch |dividend| (shifted left WIDTH/2 if FIXED_POINT), |divisor|, result sign = sign(dividend) XOR sign(divisor), dividend sign, and divisor==0. Go to DIVIDE; counter=N-1. ready_out falls the next cycle.
- DIVIDE, each cycle:
  - remainder = {remainder, next numerator MSB};
  - if remainder ≥ |divisor|, subtract it and shift in quotient bit 1, else 0;
  - decrement counter; at 0 go to FINISH.
- FINISH, one cycle:
  - Apply sign (truncation toward zero) and saturate to WIDTH bits, registered to outputs.
  - Pulse valid_out; return to IDLE.
- Latency: valid_out is high exactly N+1 cycles after the accepting cycle (WIDTH=32/FP=1: 49; WIDTH=16/FP=0: 17). ready_out is high in that same cycle; back-to-back accept is allowed there.
- valid_in while not ready: ignored, not queued; operands may change freely.
- Divide by zero:
  - Full latency still runs.
  - quotient_out = max positive (0111…1) if dividend ≥ 0, else min negative (1000…0).
  - div_by_zero_out=1, overflow_out=0.
- Overflow: magnitude exceeds the signed WIDTH range (e.g. min / -1 in integer mode, large FP quotients). Saturate to max/min by result sign; overflow_out=1.
- Min-negative dividend: |x| held in WIDTH+1 bits; no wrap.
- Flags clear on every new result.
- Reset mid-operation: abort, return to reset values, no valid_out.

Optional Feature:
- Macro: FIXED_POINT_DIVIDER_ROUND_EN.
- Defined:
  - One extra iteration produces the half-LSB bit. Magnitude is rounded half away from zero before sign application and saturation.
  - Latency becomes N+2.
  - A rounding carry that exceeds the range saturates with overflow_out=1.
- Undefined: truncation toward zero, latency N+1.

Test Plan:
- WIDTH=32, FP=1: dividend 0x00030000, divisor 0x00020000 → valid_out at cycle 49 after accept; quotient 0x00018000; flags 0. ready_out low during cycles 1..48.
- WIDTH=32, FP=1: 0xFFF90000 / 0x00020000 (-7.0/2.0) → 0xFFFC8000. Then 0x00050000 / 0 → 0x7FFFFFFF, div_by_zero_out=1. Then 0xFFFB0000 / 0 → 0x80000000, div_by_zero_out=1.
- WIDTH=32, FP=1: 0x7FFF0000 / 0x00000100 → 0x7FFFFFFF, overflow_out=1.
- WIDTH=16, FP=0:
  - 100/7 → 14 at cycle 17; -100/7 → -14 (0xFFF2).
  - 0x8000 / 0xFFFF → 0x7FFF, overflow_out=1.
  - Second op issued in the valid_out cycle is accepted; valid_in held during DIVIDE is ignored (exactly one result per accept).
- Mid-DIVIDE at cycle 20, assert rst_in one cycle → next cycle ready_out=1, outputs 0; no valid_out for 60 cycles; subsequent 6.0/3.0 → 0x00020000.
- FIXED_POINT_DIVIDER_ROUND_EN, WIDTH=32, FP=1: 0x00020000 / 0x00030000 → 0x0000AAAB at cycle 50. Without the macro → 0x0000AAAA at cycle 49.
